cache_set_ctrl: RTL
===================

Name: cache_set_ctrl

Overview:
Parametrised split-L1 cache controller core: one instance per cache (data 8-way, instruction 4-way), replacing the fixed-geometry cache/mesi_fsm/count trio. Accepts trace commands over a valid/ready handshake and performs tag lookup, true-LRU update, victim selection and MESI transitions. Emits one response per command with bus-operation and write-back indication, and maintains hit/miss statistics counters. Tag, MESI and LRU arrays are held in flops inside the block; data payload is out of scope.

Parameters:
SETS, 16, number of sets; power of two, >=2
WAYS, 8, associativity; power of two, 2..16
ADDR_W, 32, address width
OFFSET_W, 6, byte-offset bits (64 B line)
IDX_W and TAG_W are derived: IDX_W = clog2(SETS), TAG_W = ADDR_W-IDX_W-OFFSET_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept; high only in IDLE
cmd  in  4  0 rd, 1 wr, 2 ifetch, 3 L2 invalidate, 4 L2 snoop read, 8 clear; others are no-op
addr  in  ADDR_W  address; index = addr[OFFSET_W+:IDX_W], tag = upper TAG_W bits
snoop_shared  in  1  sampled at accept; another cache holds the line
resp_valid  out  1  one-cycle response pulse, no backpressure
resp_hit  out  1  tag matched a non-I way
resp_way  out  clog2(WAYS)  way hit or filled
resp_mesi  out  2  new state of that way: I=0, S=1, E=2, M=3
resp_bus_op  out  2  0 none, 1 READ, 2 RFO, 3 INVALIDATE
resp_evict  out  1  valid victim replaced
resp_wb  out  1  modified data must be written back (dirty victim or snoop of M)
resp_victim_tag  out  TAG_W  tag of evicted way
stat_reads, stat_writes, stat_hits, stat_misses  out  32 each  wrapping counters

Behaviour:
- Reset (rst=1 at edge): state IDLE; every way MESI=I, tag=0, LRU rank=way index; all counters 0; all resp_* 0; cmd_ready=1 next cycle. rst overrides everything, including an in-progress CLEAR.
- FSM: IDLE -> LOOKUP on cmd_valid&&cmd_ready (cmd and addr registered). LOOKUP -> UPDATE: hit detection, victim selection. UPDATE -> IDLE: arrays written, resp_* registered. resp_valid is high for exactly the cycle following UPDATE, i.e. 3 edges after acceptance; the next accept is possible in that same cycle. Command 8 goes IDLE -> CLEAR.
- CLEAR: one set per cycle from index 0 to SETS-1, applying the reset values for that set. After the last set, the block zeros the counters, pulses resp_valid with all other resp fields 0, and returns to IDLE. cmd_ready stays 0 throughout.
- LRU: rank 0 = MRU, WAYS-1 = LRU. An access or fill of way w with rank r increments every rank < r and sets w to 0. Snoops and invalidates leave ranks unchanged. Ranks always form a permutation.
- Victim selection: the lowest-index way in state I; if none, the way with rank WAYS-1. resp_evict=1 only when the victim is not I. resp_wb=1 when the victim is M.
- Read or ifetch hit: MESI unchanged, bus_op none. Miss: fill with new tag, S if snoop_shared else E, bus_op READ.
- Write hit: M results. From S, bus_op is INVALIDATE; from E or M, bus_op is none. Write miss: fill in M, bus_op RFO.
- Cmd 3: on a hit the way goes to I; resp_wb=1 if the way was M. On a miss there is no change.
- Cmd 4: on a hit, M goes to S with resp_wb=1; E goes to S; S stays S. On a miss there is no change. resp_hit is reported for both 3 and 4.
- Counters: stat_reads counts cmd 0 and 2; stat_writes counts cmd 1; stat_hits and stat_misses count only cmd 0, 1 and 2. Counters wrap at 2^32.
- Unrecognised cmd: the full pipeline runs, resp_valid is pulsed with all fields 0, and there is no state change.
- A tag match is only valid against a way whose MESI is not I; at most one way matches by construction.

Test Plan:
Config for all scenarios: SETS=16, WAYS=4; tag = addr[31:10], index = addr[9:6].
1. After reset, rd 0x040 with snoop_shared=0 -> resp_valid 3 edges after accept; hit=0, way=0, mesi=E, bus_op=READ, evict=0; stat_reads=1, stat_misses=1. Repeating the rd gives hit=1, way=0, mesi=E, bus_op=0, stat_hits=1.
2. rd 0x040 with snoop_shared=1, then wr 0x040 -> fill S; the write hits, mesi=M, bus_op=INVALIDATE. Then cmd 4 to 0x040 -> hit=1, mesi=S, wb=1, and stat counters unchanged.
3. Fill rd 0x040, 0x440, 0x840 and 0xC40 into ways 0-3, then rd 0x1040 -> victim is way 0; evict=1, victim_tag=0, wb=0, way=0; the ranks of ways 1-3 each increment.
4. wr 0x040 (miss, M, RFO), then three more tags to the same set, then rd 0x1040 -> the dirty victim gives evict=1, wb=1, victim_tag=0x0.
5. Cmd 3 to a missing address -> hit=0, no change. Cmd 3 to a resident M line -> hit=1, mesi=I, wb=1. A subsequent rd to that line misses.
6. Cmd 8 after traffic -> cmd_ready=0 for 16 CLEAR cycles, then resp_valid pulses and all counters read 0, and a rd to 0x040 misses. Repeat with rst asserted mid-CLEAR -> IDLE and cmd_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/cache_set_ctrl.sv
// cache_set_ctrl: one L1 cache controller core.
// Accepts trace commands over a valid/ready handshake. For each command it
// does a tag lookup, updates true-LRU ranks, picks a victim, applies the MESI
// transition and returns one response pulse. It also keeps the statistics
// counters. Tag, MESI and LRU arrays live in flops; the data payload is not
// modelled.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd, addr              command code and address
//   snoop_shared           sampled at accept; another cache holds the line
//   resp_*                 one-cycle response: hit, way, new MESI, bus op,
//                          evict, write-back, victim tag
//   stat_*                 wrapping 32-bit read/write/hit/miss counters
module cache_set_ctrl #(
   parameter int SETS     = 16,
   parameter int WAYS     = 8,
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 6,
   localparam int IDX_W   = $clog2(SETS),
   localparam int TAG_W   = ADDR_W - IDX_W - OFFSET_W,
   localparam int WAY_W   = $clog2(WAYS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd,
   input  logic [ADDR_W-1:0] addr,
   input  logic              snoop_shared,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [WAY_W-1:0]  resp_way,
   output logic [1:0]        resp_mesi,
   output logic [1:0]        resp_bus_op,
   output logic              resp_evict,
   output logic              resp_wb,
   output logic [TAG_W-1:0]  resp_victim_tag,
   output logic [31:0]       stat_reads,
   output logic [31:0]       stat_writes,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_misses
);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_CLEAR} state_e;
   typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_e;
   typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_READ = 2'd1, BUS_RFO = 2'd2, BUS_INV = 2'd3} bus_e;
   typedef enum logic [3:0] {CMD_RD = 4'd0, CMD_WR = 4'd1, CMD_IF = 4'd2, CMD_INV = 4'd3,
                             CMD_SNP = 4'd4, CMD_CLR = 4'd8} cmd_e;

   state_e             state_q, state_d;
   logic [3:0]         cmd_q;
   logic [IDX_W-1:0]   idx_q;
   logic [TAG_W-1:0]   req_tag_q;
   logic               shared_q;
   logic [IDX_W-1:0]   clr_idx_q;
   logic               clr_last;

   logic [TAG_W-1:0]   tags_q [SETS][WAYS];
   mesi_e              mesi_q [SETS][WAYS];
   logic [WAY_W-1:0]   rank_q [SETS][WAYS];

   logic               hit_c, hit_q;
   logic [WAY_W-1:0]   hway_c, hway_q, vway_c, vway_q;
   logic               inv_found;
   logic [WAY_W-1:0]   inv_way, lru_way;

   logic [WAY_W-1:0]   wr_way;
   mesi_e              old_mesi, wr_mesi;
   logic               wr_mesi_en, wr_tag_en, touch;

   logic               hit_d, evict_d, wb_d;
   logic [WAY_W-1:0]   way_d;
   mesi_e              rmesi_d;
   bus_e               bus_d;
   logic [TAG_W-1:0]   vtag_d;

   logic               resp_valid_q, resp_hit_q, resp_evict_q, resp_wb_q;
   logic [WAY_W-1:0]   resp_way_q;
   mesi_e              resp_mesi_q;
   bus_e               resp_bus_q;
   logic [TAG_W-1:0]   resp_vtag_q;
   logic [31:0]        reads_q, writes_q, hits_q, misses_q;

   // Byte-offset bits select within the line and play no part in control.
   logic unused_offset;
   assign unused_offset = ^addr[OFFSET_W-1:0];

   assign cmd_ready = (state_q == S_IDLE);
   assign clr_last  = (clr_idx_q == IDX_W'(SETS - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cmd_valid) state_d = (cmd == CMD_CLR) ? S_CLEAR : S_LOOKUP;
         S_LOOKUP: state_d = S_UPDATE;
         S_UPDATE: state_d = S_IDLE;
         S_CLEAR:  if (clr_last) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Hit way, lowest-index invalid way and the LRU way for the requested set.
   always_comb begin
      hit_c     = 1'b0;
      hway_c    = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      lru_way   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (mesi_q[idx_q][w] != MESI_I && tags_q[idx_q][w] == req_tag_q) begin
            hit_c  = 1'b1;
            hway_c = WAY_W'(w);
         end
         if (!inv_found && mesi_q[idx_q][w] == MESI_I) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
         if (rank_q[idx_q][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
      end
      vway_c = inv_found ? inv_way : lru_way;
   end

   // Array write controls and response values for the UPDATE cycle.
   always_comb begin
      wr_way     = hit_q ? hway_q : vway_q;
      old_mesi   = mesi_q[idx_q][wr_way];
      wr_mesi    = old_mesi;
      wr_mesi_en = 1'b0;
      wr_tag_en  = 1'b0;
      touch      = 1'b0;
      hit_d      = 1'b0;
      way_d      = '0;
      rmesi_d    = MESI_I;
      bus_d      = BUS_NONE;
      evict_d    = 1'b0;
      wb_d       = 1'b0;
      vtag_d     = '0;
      if (state_q == S_UPDATE) begin
         case (cmd_q)
            CMD_RD, CMD_WR, CMD_IF: begin
               touch = 1'b1;
               way_d = wr_way;
               if (hit_q) begin
                  hit_d = 1'b1;
                  if (cmd_q == CMD_WR) begin
                     wr_mesi_en = 1'b1;
                     wr_mesi    = MESI_M;
                     bus_d      = (old_mesi == MESI_S) ? BUS_INV : BUS_NONE;
                  end
               end else begin
                  wr_mesi_en = 1'b1;
                  wr_tag_en  = 1'b1;
                  if (cmd_q == CMD_WR) begin
                     wr_mesi = MESI_M;
                     bus_d   = BUS_RFO;
                  end else begin
                     wr_mesi = shared_q ? MESI_S : MESI_E;
                     bus_d   = BUS_READ;
                  end
                  evict_d = (old_mesi != MESI_I);
                  wb_d    = (old_mesi == MESI_M);
                  if (old_mesi != MESI_I) vtag_d = tags_q[idx_q][wr_way];
               end
               rmesi_d = wr_mesi;
            end
            CMD_INV: if (hit_q) begin
               hit_d      = 1'b1;
               way_d      = wr_way;
               wr_mesi_en = 1'b1;
               wr_mesi    = MESI_I;
               wb_d       = (old_mesi == MESI_M);
               rmesi_d    = MESI_I;
            end
            CMD_SNP: if (hit_q) begin
               hit_d      = 1'b1;
               way_d      = wr_way;
               wr_mesi_en = 1'b1;
               wr_mesi    = MESI_S;
               wb_d       = (old_mesi == MESI_M);
               rmesi_d    = MESI_S;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               tags_q[s][w] <= '0;
               mesi_q[s][w] <= MESI_I;
               rank_q[s][w] <= WAY_W'(w);
            end
         end
      end else if (state_q == S_CLEAR) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            tags_q[clr_idx_q][w] <= '0;
            mesi_q[clr_idx_q][w] <= MESI_I;
            rank_q[clr_idx_q][w] <= WAY_W'(w);
         end
      end else if (state_q == S_UPDATE) begin
         if (wr_mesi_en) mesi_q[idx_q][wr_way] <= wr_mesi;
         if (wr_tag_en)  tags_q[idx_q][wr_way] <= req_tag_q;
         // Ways more recent than the touched one age by one; it becomes MRU.
         if (touch) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == wr_way)
                  rank_q[idx_q][w] <= '0;
               else if (rank_q[idx_q][w] < rank_q[idx_q][wr_way])
                  rank_q[idx_q][w] <= rank_q[idx_q][w] + WAY_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q        <= '0;
         idx_q        <= '0;
         req_tag_q    <= '0;
         shared_q     <= 1'b0;
         clr_idx_q    <= '0;
         hit_q        <= 1'b0;
         hway_q       <= '0;
         vway_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_way_q   <= '0;
         resp_mesi_q  <= MESI_I;
         resp_bus_q   <= BUS_NONE;
         resp_evict_q <= 1'b0;
         resp_wb_q    <= 1'b0;
         resp_vtag_q  <= '0;
         reads_q      <= '0;
         writes_q     <= '0;
         hits_q       <= '0;
         misses_q     <= '0;
      end else begin
         if (state_q == S_IDLE) begin
            clr_idx_q <= '0;
            if (cmd_valid) begin
               cmd_q     <= cmd;
               idx_q     <= addr[OFFSET_W +: IDX_W];
               req_tag_q <= addr[ADDR_W-1 -: TAG_W];
               shared_q  <= snoop_shared;
            end
         end
         if (state_q == S_CLEAR) clr_idx_q <= clr_idx_q + IDX_W'(1);
         if (state_q == S_LOOKUP) begin
            hit_q  <= hit_c;
            hway_q <= hway_c;
            vway_q <= vway_c;
         end
         resp_valid_q <= (state_q == S_UPDATE) || (state_q == S_CLEAR && clr_last);
         resp_hit_q   <= hit_d;
         resp_way_q   <= way_d;
         resp_mesi_q  <= rmesi_d;
         resp_bus_q   <= bus_d;
         resp_evict_q <= evict_d;
         resp_wb_q    <= wb_d;
         resp_vtag_q  <= vtag_d;
         if (state_q == S_UPDATE) begin
            if (cmd_q == CMD_RD || cmd_q == CMD_IF) reads_q  <= reads_q + 32'd1;
            if (cmd_q == CMD_WR)                    writes_q <= writes_q + 32'd1;
            if (cmd_q == CMD_RD || cmd_q == CMD_IF || cmd_q == CMD_WR) begin
               if (hit_q) hits_q   <= hits_q + 32'd1;
               else       misses_q <= misses_q + 32'd1;
            end
         end
         if (state_q == S_CLEAR && clr_last) begin
            reads_q  <= '0;
            writes_q <= '0;
            hits_q   <= '0;
            misses_q <= '0;
         end
      end
   end

   assign resp_valid      = resp_valid_q;
   assign resp_hit        = resp_hit_q;
   assign resp_way        = resp_way_q;
   assign resp_mesi       = resp_mesi_q;
   assign resp_bus_op     = resp_bus_q;
   assign resp_evict      = resp_evict_q;
   assign resp_wb         = resp_wb_q;
   assign resp_victim_tag = resp_vtag_q;
   assign stat_reads      = reads_q;
   assign stat_writes     = writes_q;
   assign stat_hits       = hits_q;
   assign stat_misses     = misses_q;

endmodule
